// File: rtl/mem_arb_pkg.sv
// Shared constants for the memory access arbiter:
// FSM encodings, arbitration modes and requester indices.
package mem_arb_pkg;

    localparam logic [1:0] ST_RESET = 2'b11;
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_LOAD  = 2'b10;
    localparam logic [1:0] ST_STORE = 2'b01;

    localparam int RR_FIXED = 0;
    localparam int RR_ROUND = 1;

    localparam int REQ_FETCH  = 0;
    localparam int REQ_DECODE = 1;

endpackage

// File: rtl/mem_access_arbiter_prio_picker.sv
// Combinational winner selection: fixed priority (highest index)
// or round-robin search upward from ptr, wrapping.
module prio_picker
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 3,
    parameter int MODE    = RR_FIXED
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   idx
);

    logic found;
    int   j;

    // Pick one requester; the later loop hit overrides in fixed mode.
    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        j      = 0;
        if (MODE == RR_FIXED) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req[i]) begin
                    onehot    = '0;
                    onehot[i] = 1'b1;
                    idx       = IDX_W'(i);
                end
            end
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                j = (int'(ptr) + k) % NUM_REQ;
                if (!found && req[j]) begin
                    found     = 1'b1;
                    onehot[j] = 1'b1;
                    idx       = IDX_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/mem_access_arbiter.sv
// Shared memory port arbiter: grants one requester at a time and
// tracks the load/store access until completion or timeout.
module mem_access_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int IDX_W          = 3,
    parameter int RR_MODE        = RR_FIXED,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_load_in,
    input  logic [NUM_REQ-1:0] req_store_in,
    input  logic               mem_output_valid_in,
    input  logic               mem_write_ready_in,
    output logic [NUM_REQ-1:0] grant_out,
    output logic [IDX_W-1:0]   grant_idx_out,
    output logic [NUM_REQ-1:0] stall_out,
    output logic               read_en_out,
    output logic               write_en_out,
    output logic               timeout_err_out,
    output logic [1:0]         state
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] pick_oh;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   ptr_next;
    logic [7:0]         timer;
    logic               in_acc;
    logic               done;
    logic               timeout_hit;
    logic               finish;

    assign req    = req_load_in | req_store_in;
    assign in_acc = (state == ST_LOAD) || (state == ST_STORE);
    assign done   = ((state == ST_LOAD) && mem_output_valid_in) ||
                    ((state == ST_STORE) && mem_write_ready_in);

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && in_acc &&
                         !done && (timer == TO_LAST);
    assign finish      = done || timeout_hit;

    assign ptr_next = (grant_idx_out >= LAST_IDX) ? '0
                    : grant_idx_out + 1'b1;

    prio_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W),
        .MODE    (RR_MODE)
    ) u_pick (
        .req    (req),
        .ptr    (rr_ptr),
        .onehot (pick_oh),
        .idx    (pick_idx)
    );

    assign read_en_out  = (state == ST_LOAD);
    assign write_en_out = (state == ST_STORE);
    assign stall_out    = (state == ST_RESET) ? '0
                        : req & ~(grant_out & {NUM_REQ{done}});

    // FSM, grant registers, RR pointer and access timer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_RESET;
            grant_out       <= '0;
            grant_idx_out   <= '0;
            rr_ptr          <= '0;
            timer           <= '0;
            timeout_err_out <= 1'b0;
        end else begin
            timeout_err_out <= timeout_hit;
            case (state)
                ST_RESET: state <= ST_IDLE;
                ST_IDLE: begin
                    if (|req) begin
                        grant_out     <= pick_oh;
                        grant_idx_out <= pick_idx;
                        timer         <= '0;
                        state         <= (|(req_store_in & pick_oh))
                                         ? ST_STORE : ST_LOAD;
                    end
                end
                ST_LOAD, ST_STORE: begin
                    if (finish) begin
                        state     <= ST_IDLE;
                        grant_out <= '0;
                        rr_ptr    <= ptr_next;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Bench: instance A (2 req, fixed) driven from a vector table,
// instance B (4 req, round-robin, timeout 4) via scoreboard/sequences.
module tb_mem_access_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [1:0] ld_a = '0, st_a = '0;
    logic       vld_a = 1'b0, wr_a = 1'b0;
    logic [1:0] g_a, stl_a, s_a;
    logic [2:0] gi_a;
    logic       rd_en_a, wr_en_a, err_a;

    logic [3:0] ld_b = '0, st_b = '0;
    logic       vld_b = 1'b0, wr_b = 1'b0;
    logic [3:0] g_b, stl_b;
    logic [1:0] s_b;
    logic [2:0] gi_b;
    logic       rd_en_b, wr_en_b, err_b;

    mem_access_arbiter #(
        .NUM_REQ(2), .IDX_W(3), .RR_MODE(0), .TIMEOUT_CYCLES(0)
    ) dut_a (
        .clk(clk), .reset(reset),
        .req_load_in(ld_a), .req_store_in(st_a),
        .mem_output_valid_in(vld_a), .mem_write_ready_in(wr_a),
        .grant_out(g_a), .grant_idx_out(gi_a), .stall_out(stl_a),
        .read_en_out(rd_en_a), .write_en_out(wr_en_a),
        .timeout_err_out(err_a), .state(s_a)
    );

    mem_access_arbiter #(
        .NUM_REQ(4), .IDX_W(3), .RR_MODE(1), .TIMEOUT_CYCLES(4)
    ) dut_b (
        .clk(clk), .reset(reset),
        .req_load_in(ld_b), .req_store_in(st_b),
        .mem_output_valid_in(vld_b), .mem_write_ready_in(wr_b),
        .grant_out(g_b), .grant_idx_out(gi_b), .stall_out(stl_b),
        .read_en_out(rd_en_b), .write_en_out(wr_en_b),
        .timeout_err_out(err_b), .state(s_b)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0] ld, st;
        logic       vld, wrdy;
        logic [1:0] est, eg;
        logic [2:0] eidx;
        logic [1:0] estl;
        logic       erd, ewr;
    } vec_t;

    function automatic vec_t mk(logic [1:0] ld, logic [1:0] st,
        logic vld, logic wrdy, logic [1:0] est, logic [1:0] eg,
        logic [2:0] eidx, logic [1:0] estl, logic erd, logic ewr);
        vec_t v;
        v.ld = ld; v.st = st; v.vld = vld; v.wrdy = wrdy;
        v.est = est; v.eg = eg; v.eidx = eidx; v.estl = estl;
        v.erd = erd; v.ewr = ewr;
        return v;
    endfunction

    vec_t tbl[13];
    int   exp_q[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int prev, cyc, e;
        tbl[0]  = mk(2'b11, 2'b00, 0, 0, ST_IDLE,  2'b00, 0, 2'b11, 0, 0);
        tbl[1]  = mk(2'b11, 2'b00, 0, 0, ST_LOAD,  2'b10, 1, 2'b11, 1, 0);
        tbl[2]  = mk(2'b11, 2'b00, 0, 0, ST_LOAD,  2'b10, 1, 2'b11, 1, 0);
        tbl[3]  = mk(2'b11, 2'b00, 1, 0, ST_LOAD,  2'b10, 1, 2'b01, 1, 0);
        tbl[4]  = mk(2'b01, 2'b00, 0, 0, ST_IDLE,  2'b00, 0, 2'b01, 0, 0);
        tbl[5]  = mk(2'b01, 2'b00, 0, 1, ST_LOAD,  2'b01, 0, 2'b01, 1, 0);
        tbl[6]  = mk(2'b01, 2'b00, 1, 0, ST_LOAD,  2'b01, 0, 2'b00, 1, 0);
        tbl[7]  = mk(2'b10, 2'b10, 0, 0, ST_IDLE,  2'b00, 0, 2'b10, 0, 0);
        tbl[8]  = mk(2'b10, 2'b10, 1, 0, ST_STORE, 2'b10, 1, 2'b10, 0, 1);
        tbl[9]  = mk(2'b00, 2'b00, 0, 0, ST_STORE, 2'b10, 1, 2'b00, 0, 1);
        tbl[10] = mk(2'b00, 2'b00, 0, 1, ST_STORE, 2'b10, 1, 2'b00, 0, 1);
        tbl[11] = mk(2'b00, 2'b00, 1, 1, ST_IDLE,  2'b00, 0, 2'b00, 0, 0);
        tbl[12] = mk(2'b00, 2'b00, 0, 0, ST_IDLE,  2'b00, 0, 2'b00, 0, 0);

        // reset held three cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("rst_state", s_a, ST_RESET);
            chk("rst_grant", g_a, 0);
            chk("rst_stall", stl_a, 0);
            chk("rst_rdwr", {rd_en_a, wr_en_a, err_a}, 0);
            chk("rst_state_b", s_b, ST_RESET);
        end
        reset = 1'b0;

        // table on instance A
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            ld_a = tbl[i].ld; st_a = tbl[i].st;
            vld_a = tbl[i].vld; wr_a = tbl[i].wrdy;
            #1;
            chk($sformatf("v%0d_state", i), s_a, tbl[i].est);
            chk($sformatf("v%0d_grant", i), g_a, tbl[i].eg);
            chk($sformatf("v%0d_stall", i), stl_a, tbl[i].estl);
            chk($sformatf("v%0d_rd", i), rd_en_a, tbl[i].erd);
            chk($sformatf("v%0d_wr", i), wr_en_a, tbl[i].ewr);
            chk($sformatf("v%0d_err", i), err_a, 0);
            if (tbl[i].eg != 2'b00)
                chk($sformatf("v%0d_idx", i), gi_a, tbl[i].eidx);
        end

        // round-robin scoreboard on instance B
        exp_q = '{0, 1, 2, 3, 0};
        @(negedge clk);
        ld_b = 4'b1111; vld_b = 1'b1;
        prev = -1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 40) begin
            @(negedge clk); #1;
            cyc++;
            if (g_b != 4'b0000) begin
                e = exp_q.pop_front();
                chk("rr_grant", g_b, 32'(1) << e);
                chk("rr_idx", gi_b, e);
                if (prev >= 0) chk("rr_gap", cyc - prev, 2);
                prev = cyc;
                if (exp_q.size() == 0) ld_b = 4'b0000;
            end
        end
        chk("rr_left", exp_q.size(), 0);

        // timeout on requester 1 after four access cycles
        @(negedge clk);
        vld_b = 1'b0; ld_b = 4'b0010;
        #1 chk("to_idle0", s_b, ST_IDLE);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk("to_load", s_b, ST_LOAD);
            chk("to_grant", g_b, 4'b0010);
            chk("to_noerr", err_b, 0);
        end
        @(negedge clk); #1;
        chk("to_state", s_b, ST_IDLE);
        chk("to_err", err_b, 1);
        chk("to_gclr", g_b, 0);
        ld_b = 4'b1010;
        @(negedge clk); #1;
        chk("to_ptr_grant", g_b, 4'b1000);
        chk("to_pulse1", err_b, 0);
        ld_b = 4'b0000; vld_b = 1'b1;
        @(negedge clk);
        vld_b = 1'b0;
        #1 chk("to_after", s_b, ST_IDLE);

        // reset during a store on instance A
        st_a = 2'b01;
        #1 chk("r6_idle", s_a, ST_IDLE);
        @(negedge clk); #1;
        chk("r6_store", s_a, ST_STORE);
        chk("r6_wr", wr_en_a, 1);
        reset = 1'b1; st_a = 2'b00;
        @(negedge clk); #1;
        chk("r6_rst", s_a, ST_RESET);
        chk("r6_grant", g_a, 0);
        chk("r6_outs", {rd_en_a, wr_en_a, err_a, stl_a}, 0);
        reset = 1'b0;
        @(negedge clk); #1;
        chk("r6_idle2", s_a, ST_IDLE);
        chk("r6_noerr", err_a, 0);
        ld_a = 2'b01;
        @(negedge clk); #1;
        chk("r6_regrant", g_a, 2'b01);
        chk("r6_load", s_a, ST_LOAD);
        chk("r6_idx", gi_a, 0);
        vld_a = 1'b1;
        @(negedge clk);
        vld_a = 1'b0; ld_a = 2'b00;
        #1 chk("r6_done", s_a, ST_IDLE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
